// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB3 word-organised RAM slave with programmable wait states
// and PSLVERR on misaligned or out-of-range addresses.
//
// Optional feature macro: APB_STRB_EN (adds the strb port and byte-lane writes).
//
// Ports:
//   clk     in   clock, all state on the rising edge
//   rst     in   asynchronous reset, active-high
//   addr    in   byte address (PADDR)
//   wdata   in   write data (PWDATA)
//   strb    in   byte write strobes (PSTRB), APB_STRB_EN builds only
//   sel     in   slave select (PSEL)
//   enable  in   access phase (PENABLE)
//   wr      in   1 = write, 0 = read (PWRITE)
//   ready   out  transfer complete (PREADY), registered
//   slverr  out  transfer error (PSLVERR), non-zero only while ready=1
//   rdata   out  read data (PRDATA), non-zero only while ready=1
module apb_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 48,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef APB_STRB_EN
  input  logic [DATA_WIDTH/8-1:0] strb,
`endif
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    wr,
  output logic                    ready,
  output logic                    slverr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef APB_STRB_EN
  logic [NB-1:0]         strb_q, strb_d;
`endif

  // Setup-phase address decode.
  logic [ADDR_WIDTH-1:0] word_c;
  logic                  err_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  we_c;
  logic [NB-1:0]         lane_en_c;

  assign word_c = addr >> OFF;
  assign err_c  = (|(addr & ALIGN_MASK)) | ({1'b0, word_c} >= DEPTH_LIM);
  assign idx_c  = word_c[IDX_W-1:0];

  // Writes commit only at the close of the single ready cycle.
  assign we_c = (state_q == S_ACCESS) && ready_q && wr_q && !err_q;

`ifdef APB_STRB_EN
  assign lane_en_c = strb_q;
`else
  assign lane_en_c = '1;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
`ifdef APB_STRB_EN
    strb_d   = strb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel && !enable) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
          idx_d   = idx_c;
          wr_d    = wr;
          err_d   = err_c;
          wdata_d = wdata;
`ifdef APB_STRB_EN
          strb_d  = strb;
`endif
          // Zero wait states: ready rises at the setup edge itself.
          if (WAIT_STATES == 0) begin
            ready_d  = 1'b1;
            slverr_d = err_c;
            rdata_d  = (!wr && !err_c) ? mem[idx_c] : '0;
          end
        end
      end
      S_ACCESS: begin
        if (ready_q) begin
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          rdata_d  = '0;
          state_d  = S_IDLE;
        end else if (!sel) begin
          state_d = S_IDLE;
        end else if (enable) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            ready_d  = 1'b1;
            slverr_d = err_q;
            rdata_d  = (!wr_q && !err_q) ? mem[idx_q] : '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
`ifdef APB_STRB_EN
      strb_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
`ifdef APB_STRB_EN
      strb_q   <= strb_d;
`endif
    end
  end

  // RAM array, not reset; reset clears ready_q so no write can commit.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (lane_en_c[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ready  = ready_q;
  assign slverr = slverr_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = 4'hF;
  logic        sel = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic        ready;
  logic        slverr;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat;
  logic        err;
  logic [31:0] data;

  apb_mem_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(48), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
`ifdef APB_STRB_EN
    .strb(strb),
`endif
    .sel(sel), .enable(enable), .wr(wr),
    .ready(ready), .slverr(slverr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  // Setup phase then access cycles until ready is seen; returns in the ready cycle.
  // addr/wdata are scrambled during access to prove captured values are used.
  task automatic start_to_ready(input logic [7:0] a, input logic w, input logic [31:0] d,
                                output int n);
    sel = 1'b1; enable = 1'b0; addr = a; wr = w; wdata = d;
    @(posedge clk); #1;
    enable = 1'b1; addr = 8'hFF; wdata = ~d;
    n = 0;
    forever begin
      n++;
      if (ready === 1'b1 || n >= 20) break;
      @(posedge clk); #1;
    end
    chk("no_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic finish_xfer;
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    chk("ready_low_after", {31'b0, ready}, 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, output logic e, output int n);
    start_to_ready(a, 1'b1, d, n);
    e = slverr;
    finish_xfer();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] q, output logic e, output int n);
    start_to_ready(a, 1'b0, 32'h0, n);
    q = rdata;
    e = slverr;
    finish_xfer();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_slverr", {31'b0, slverr}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write/read with latency
    do_write(8'h10, 32'hDEADBEEF, err, lat);
    chk("wr10_lat", 32'(lat), 32'(WS + 1));
    chk("wr10_err", {31'b0, err}, 32'd0);
    do_read(8'h10, data, err, lat);
    chk("rd10_lat", 32'(lat), 32'(WS + 1));
    chk("rd10_data", data, 32'hDEADBEEF);
    chk("rd10_err", {31'b0, err}, 32'd0);
    chk("idle_rdata", rdata, 32'h0);

    do_write(8'h00, 32'hA5A50001, err, lat);
    do_write(8'h08, 32'h12345678, err, lat);
    do_write(8'hBC, 32'h0BADF00D, err, lat);
    chk("wrBC_err", {31'b0, err}, 32'd0);
    do_read(8'hBC, data, err, lat);
    chk("rdBC_data", data, 32'h0BADF00D);

    // Out-of-range
    do_write(8'hC0, 32'hFFFF0000, err, lat);
    chk("wrC0_err", {31'b0, err}, 32'd1);
    do_read(8'hFC, data, err, lat);
    chk("rdFC_err", {31'b0, err}, 32'd1);
    chk("rdFC_data", data, 32'h0);
    do_read(8'h00, data, err, lat);
    chk("rd00_data", data, 32'hA5A50001);

    // Misaligned
    do_read(8'h11, data, err, lat);
    chk("rd11_err", {31'b0, err}, 32'd1);
    chk("rd11_data", data, 32'h0);
    do_write(8'h12, 32'hFFFFFFFF, err, lat);
    chk("wr12_err", {31'b0, err}, 32'd1);
    do_read(8'h10, data, err, lat);
    chk("rd10_intact", data, 32'hDEADBEEF);

    // Abort by dropping sel in the wait cycle
    do_write(8'h20, 32'h11112222, err, lat);
    sel = 1'b1; enable = 1'b0; addr = 8'h20; wr = 1'b1; wdata = 32'h55;
    @(posedge clk); #1 enable = 1'b1;
    chk("abort_wait_ready", {31'b0, ready}, 32'd0);
    #2 sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready0", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_ready1", {31'b0, ready}, 32'd0);
    do_read(8'h20, data, err, lat);
    chk("rd20_old", data, 32'h11112222);

    // Access phase without setup is ignored
    sel = 1'b1; enable = 1'b1; addr = 8'h10; wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("nosetup_ready", {31'b0, ready}, 32'd0);
    end
    sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1;

    // Reset during the ready cycle of an erroring read clears outputs at once
    start_to_ready(8'hFC, 1'b0, 32'h0, lat);
    chk("pre_rst_slverr", {31'b0, slverr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'b0, ready}, 32'd0);
    chk("async_rst_slverr", {31'b0, slverr}, 32'd0);
    chk("async_rst_rdata", rdata, 32'h0);
    sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Reset during the ready cycle of a write: no commit
    start_to_ready(8'h08, 1'b1, 32'hCAFEF00D, lat);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0; rst = 1'b0;
    do_read(8'h08, data, err, lat);
    chk("rd08_nocommit", data, 32'h12345678);

`ifdef APB_STRB_EN
    strb = 4'hF;
    do_write(8'h04, 32'h11223344, err, lat);
    strb = 4'b0101;
    do_write(8'h04, 32'hAABBCCDD, err, lat);
    strb = 4'b0000;
    do_write(8'h04, 32'h99999999, err, lat);
    chk("strb0_err", {31'b0, err}, 32'd0);
    strb = 4'hF;
    do_read(8'h04, data, err, lat);
    chk("strb_merge", data, 32'h11BB33DD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
